// File: rtl/serial_addsub.sv
`timescale 1ns/1ps
// Bit-serial add/subtract, LSB first: accept in IDLE, WIDTH RUN cycles, one DONE cycle (start ignored while busy/done).
// Optional signed-overflow output `ovf` is built only when SERIAL_ADDSUB_OVF_EN is defined.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             mode_r;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             accept, last_bit;
  logic             x, y, s, c_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        accept    = 1'b1;
      end
      RUN:  if (last_bit) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // One shared full adder / full subtractor cell on the current LSBs.
  assign x        = a_sh[0];
  assign y        = b_sh[0];
  assign s        = x ^ y ^ c;
  assign c_nxt    = mode_r ? ((~x & y) | (~(x ^ y) & c))
                           : ((x & y)  | ((x ^ y) & c));
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      mode_r <= 1'b0;
      c      <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      mode_r <= mode;
      c      <= 1'b0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      c      <= c_nxt;
      cnt    <= cnt + CW'(1);
      result <= {s, result[WIDTH-1:1]};
      cout   <= c_nxt;
`ifdef SERIAL_ADDSUB_OVF_EN
      // Updated every bit; only the value computed on the MSB survives to done.
      ovf    <= mode_r ? ((x ^ y) & (s ^ x)) : (c ^ c_nxt);
`endif
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
`timescale 1ns/1ps
// Scoreboard bench for serial_addsub: WIDTH=8 (directed + random) and WIDTH=32 (random) instances.
module tb_serial_addsub;

  localparam int W8  = 8;
  localparam int W32 = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8_n, start8, mode8, busy8, done8, cout8;
  logic [7:0]  a8, b8, res8;
  logic        rst32_n, start32, mode32, busy32, done32, cout32;
  logic [31:0] a32, b32, res32;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic        ovf8, ovf32;
`endif

  serial_addsub #(.WIDTH(W8)) u8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8),
`ifdef SERIAL_ADDSUB_OVF_EN
    .ovf(ovf8),
`endif
    .cout(cout8));

  serial_addsub #(.WIDTH(W32)) u32 (
    .clk(clk), .rst_n(rst32_n), .start(start32), .mode(mode32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32),
`ifdef SERIAL_ADDSUB_OVF_EN
    .ovf(ovf32),
`endif
    .cout(cout32));

  typedef struct {
    longint unsigned res;
    bit              cout;
    bit              ovf;
    longint          done_at;
  } exp_t;

  exp_t   q8[$], q32[$];
  exp_t   e8, e32;
  longint la8 = -1000, la32 = -1000;
  longint d8, d32;
  longint cyc = 0;
  int     nchk = 0, nfail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input bit m, input longint unsigned a, input longint unsigned b,
                                 input int w, input longint at);
    exp_t            e;
    longint unsigned md;
    longint          sa, sb, sr, half;
    md   = 64'd1 << w;
    half = longint'(md / 2);
    if (!m) begin
      e.res  = (a + b) % md;
      e.cout = (a + b) >= md;
    end else begin
      e.res  = (a + md - b) % md;
      e.cout = a < b;
    end
    sa = (longint'(a) >= half) ? longint'(a) - longint'(md) : longint'(a);
    sb = (longint'(b) >= half) ? longint'(b) - longint'(md) : longint'(b);
    sr = m ? sa - sb : sa + sb;
    e.ovf     = (sr < -half) || (sr >= half);
    e.done_at = at;
    return e;
  endfunction

  // Drives start for the next edge; the model accepts only when the engine is idle.
  task automatic issue8(input bit m, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    start8 = 1'b1; mode8 = m; a8 = a; b8 = b;
    if (cyc + 1 - la8 >= W8 + 2) begin
      la8 = cyc + 1;
      q8.push_back(model(m, a, b, W8, la8 + W8));
    end
  endtask

  task automatic op8(input bit m, input logic [7:0] a, input logic [7:0] b);
    issue8(m, a, b);
    @(posedge clk); #1;
    start8 = 1'b0; a8 = $urandom; b8 = $urandom; mode8 = ~m;
    repeat (W8 + 1) @(posedge clk);
  endtask

  task automatic issue32(input bit m, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start32 = 1'b1; mode32 = m; a32 = a; b32 = b;
    if (cyc + 1 - la32 >= W32 + 2) begin
      la32 = cyc + 1;
      q32.push_back(model(m, a, b, W32, la32 + W32));
    end
    @(posedge clk); #1;
    start32 = 1'b0; a32 = $urandom; b32 = $urandom;
    repeat (W32 + 1) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (rst8_n) begin
      d8 = cyc - la8;
      chk("busy8", busy8, (d8 >= 0 && d8 < W8));
      chk("done8", done8, (d8 == W8));
      if (done8) begin
        if (q8.size() == 0) chk("done8_unexpected", 1, 0);
        else begin
          e8 = q8.pop_front();
          chk("result8", res8, e8.res);
          chk("cout8", cout8, e8.cout);
          chk("done8_cycle", cyc, e8.done_at);
`ifdef SERIAL_ADDSUB_OVF_EN
          chk("ovf8", ovf8, e8.ovf);
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst32_n) begin
      d32 = cyc - la32;
      chk("busy32", busy32, (d32 >= 0 && d32 < W32));
      if (done32) begin
        if (q32.size() == 0) chk("done32_unexpected", 1, 0);
        else begin
          e32 = q32.pop_front();
          chk("result32", res32, e32.res);
          chk("cout32", cout32, e32.cout);
          chk("done32_cycle", cyc, e32.done_at);
`ifdef SERIAL_ADDSUB_OVF_EN
          chk("ovf32", ovf32, e32.ovf);
`endif
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, nfail=%0d", nfail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst8_n = 1'b0; rst32_n = 1'b0;
    start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
    start32 = 1'b0; mode32 = 1'b0; a32 = '0; b32 = '0;
    #1;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_result8", res8, 0);
    chk("rst_cout8", cout8, 0);
    chk("rst_busy32", busy32, 0);
    chk("rst_result32", res32, 0);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk("rst_ovf8", ovf8, 0);
`endif
    repeat (2) @(posedge clk);
    #3; rst8_n = 1'b1; rst32_n = 1'b1;

    fork
      begin
        op8(1'b0, 8'h35, 8'h4A);
        op8(1'b0, 8'hFF, 8'h01);
        op8(1'b1, 8'h10, 8'h20);
        op8(1'b1, 8'h20, 8'h10);
        op8(1'b0, 8'h7F, 8'h01);
        op8(1'b1, 8'h80, 8'h01);
        op8(1'b0, 8'h10, 8'h10);

        // start held every cycle: only idle-state requests may be accepted
        for (int i = 0; i < 40; i++)
          issue8(i[0], i[0] ? 8'hA5 : 8'h3C, i[0] ? 8'h5A : 8'hC3);
        @(posedge clk); #1; start8 = 1'b0;
        repeat (W8 + 2) @(posedge clk);

        // async reset in the middle of RUN cycle 4
        issue8(1'b0, 8'h35, 8'h4A);
        @(posedge clk); #1; start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3; rst8_n = 1'b0;
        #1;
        chk("midrst_busy8", busy8, 0);
        chk("midrst_done8", done8, 0);
        chk("midrst_result8", res8, 0);
        chk("midrst_cout8", cout8, 0);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("midrst_ovf8", ovf8, 0);
`endif
        q8.delete();
        la8 = -1000;
        @(posedge clk); #3; rst8_n = 1'b1;
        op8(1'b1, 8'h4A, 8'h35);

        for (int i = 0; i < 1000; i++)
          op8(1'($urandom), 8'($urandom), 8'($urandom));
      end
      begin
        issue32(1'b0, 32'hFFFF_FFFF, 32'h1);
        issue32(1'b1, 32'h0, 32'h1);
        issue32(1'b0, 32'h7FFF_FFFF, 32'h1);
        for (int i = 0; i < 1000; i++)
          issue32(1'($urandom), $urandom, $urandom);
      end
    join

    repeat (4) @(posedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q32_drained", q32.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
